// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// step_sequencer : step period timer and 4-coil full/half-step phase driver
// Revision       : 1.0
// ============================================================================
module step_sequencer #(
   parameter int CNT_W        = 35,
   parameter int POS_W        = 16,
   parameter int HOLD_TORQUE  = 1,
   parameter int RESET_PERIOD = 750000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             dir,
   input  logic             step,
   input  logic [CNT_W-1:0] time_to_count,
   output logic [3:0]       coils,
   output logic             step_tick,
   output logic [2:0]       phase_idx,
   output logic [POS_W-1:0] position
);

   localparam logic [CNT_W-1:0] C_RESET_PERIOD = CNT_W'(RESET_PERIOD);
   localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [3:0]       r_coils;
   logic             r_tick;
   logic [2:0]       r_idx;
   logic [POS_W-1:0] r_pos;

   logic [CNT_W-1:0] w_ttc_eff;
   logic             w_terminal;
   logic [2:0]       w_mag;
   logic [2:0]       w_next_idx;
   logic [POS_W-1:0] w_next_pos;
   logic [3:0]       w_cur_coils;
   logic [3:0]       w_idle_coils;

   function automatic logic [3:0] phase_coils(input logic [2:0] idx);
      logic [3:0] pat;
      case (idx)
         3'd0:    pat = 4'b1000;
         3'd1:    pat = 4'b1100;
         3'd2:    pat = 4'b0100;
         3'd3:    pat = 4'b0110;
         3'd4:    pat = 4'b0010;
         3'd5:    pat = 4'b0011;
         3'd6:    pat = 4'b0001;
         default: pat = 4'b1001;
      endcase
      return pat;
   endfunction

   assign w_ttc_eff  = (time_to_count == '0) ? C_ONE : time_to_count;
   assign w_terminal = (r_cnt == (r_period - C_ONE));

   // Full-step from an even (single-coil) phase moves one slot to land on the
   // two-coil odd phases; afterwards it strides by two.
   assign w_mag      = (step && r_idx[0]) ? 3'd2 : 3'd1;
   assign w_next_idx = dir ? (r_idx + w_mag) : (r_idx - w_mag);
   assign w_next_pos = dir ? (r_pos + POS_W'(w_mag)) : (r_pos - POS_W'(w_mag));

   assign w_cur_coils  = phase_coils(r_idx);
   assign w_idle_coils = (HOLD_TORQUE != 0) ? w_cur_coils : 4'b0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_period <= C_RESET_PERIOD;
         r_coils  <= 4'b0000;
         r_tick   <= 1'b0;
         r_idx    <= 3'd0;
         r_pos    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tick <= 1'b0;
               r_cnt  <= '0;
               if (enable) begin
                  r_state  <= S_RUN;
                  r_period <= w_ttc_eff;
                  r_coils  <= w_cur_coils;
               end else begin
                  r_coils  <= w_idle_coils;
               end
            end
            S_RUN: begin
               // Dropping enable beats a coincident terminal count.
               if (!enable) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_tick  <= 1'b0;
                  r_coils <= w_idle_coils;
               end else if (w_terminal) begin
                  r_cnt    <= '0;
                  r_tick   <= 1'b1;
                  r_period <= w_ttc_eff;
                  r_idx    <= w_next_idx;
                  r_coils  <= phase_coils(w_next_idx);
                  r_pos    <= w_next_pos;
               end else begin
                  r_cnt   <= r_cnt + C_ONE;
                  r_tick  <= 1'b0;
                  r_coils <= w_cur_coils;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_tick  <= 1'b0;
            end
         endcase
      end
   end

   assign coils     = r_coils;
   assign step_tick = r_tick;
   assign phase_idx = r_idx;
   assign position  = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// tb_step_sequencer : directed vector bench for step_sequencer
// Revision          : 1.0
// ============================================================================
module tb_step_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        dir = 1'b1;
   logic        step = 1'b0;
   logic [34:0] time_to_count = 35'd4;

   logic [3:0]  coils_h, coils_n;
   logic        tick_h, tick_n;
   logic [2:0]  idx_h, idx_n;
   logic [15:0] pos_h, pos_n;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   step_sequencer #(.CNT_W(35), .POS_W(16), .HOLD_TORQUE(1), .RESET_PERIOD(750000)) u_hold (
      .clk(clk), .rst(rst), .enable(enable), .dir(dir), .step(step),
      .time_to_count(time_to_count), .coils(coils_h), .step_tick(tick_h),
      .phase_idx(idx_h), .position(pos_h)
   );

   step_sequencer #(.CNT_W(35), .POS_W(16), .HOLD_TORQUE(0), .RESET_PERIOD(750000)) u_nohold (
      .clk(clk), .rst(rst), .enable(enable), .dir(dir), .step(step),
      .time_to_count(time_to_count), .coils(coils_n), .step_tick(tick_n),
      .phase_idx(idx_n), .position(pos_n)
   );

   typedef struct {
      logic        rst_first;
      logic        en;
      logic        dr;
      logic        stp;
      logic [34:0] ttc;
      int          mid;
      logic [34:0] ttc2;
      int          interval;
      logic [3:0]  coils;
      logic [2:0]  idx;
      logic [15:0] pos;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic d, input logic s,
                      input logic [34:0] t, input int m, input logic [34:0] t2,
                      input int iv, input logic [3:0] c, input logic [2:0] i,
                      input logic [15:0] p);
      vec_t v;
      v.rst_first = r; v.en = e; v.dr = d; v.stp = s; v.ttc = t; v.mid = m;
      v.ttc2 = t2; v.interval = iv; v.coils = c; v.idx = i; v.pos = p;
      vecs.push_back(v);
   endtask

   task automatic tick_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // half-step forward, ttc=4, through the 7->0 wrap
      add(0,1,1,0, 35'd4, 0,35'd0, 5, 4'b1100, 3'd1, 16'd1);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b0100, 3'd2, 16'd2);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b0110, 3'd3, 16'd3);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b0010, 3'd4, 16'd4);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b0011, 3'd5, 16'd5);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b0001, 3'd6, 16'd6);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b1001, 3'd7, 16'd7);
      add(0,1,1,0, 35'd4, 0,35'd0, 4, 4'b1000, 3'd0, 16'd8);
      // full-step forward from idx0 (realign +1, then +2), ttc=3
      add(0,1,1,1, 35'd3, 0,35'd0, 4, 4'b1100, 3'd1, 16'd9);
      add(0,1,1,1, 35'd3, 0,35'd0, 3, 4'b0110, 3'd3, 16'd11);
      add(0,1,1,1, 35'd3, 0,35'd0, 3, 4'b0011, 3'd5, 16'd13);
      add(0,1,1,1, 35'd3, 0,35'd0, 3, 4'b1001, 3'd7, 16'd15);
      add(0,1,1,1, 35'd3, 0,35'd0, 3, 4'b1100, 3'd1, 16'd17);
      // ttc 10 -> 2 changed mid-period: that period still lasts 10
      add(0,1,1,1, 35'd10,0,35'd0, 3, 4'b0110, 3'd3, 16'd19);
      add(0,1,1,1, 35'd10,5,35'd2, 10,4'b0011, 3'd5, 16'd21);
      add(0,1,1,1, 35'd2, 0,35'd0, 2, 4'b1001, 3'd7, 16'd23);
      // ttc=0 behaves as 1: a step every clock
      add(0,1,1,0, 35'd0, 0,35'd0, 2, 4'b1000, 3'd0, 16'd24);
      add(0,1,1,0, 35'd0, 0,35'd0, 1, 4'b1100, 3'd1, 16'd25);
      add(0,1,1,0, 35'd0, 0,35'd0, 1, 4'b0100, 3'd2, 16'd26);
      // reverse from a fresh reset, half then full step
      add(1,1,0,0, 35'd2, 0,35'd0, 3, 4'b1001, 3'd7, 16'hFFFF);
      add(0,1,0,0, 35'd2, 0,35'd0, 2, 4'b0001, 3'd6, 16'hFFFE);
      add(0,1,0,0, 35'd2, 0,35'd0, 2, 4'b0011, 3'd5, 16'hFFFD);
      add(0,1,0,1, 35'd2, 0,35'd0, 2, 4'b0110, 3'd3, 16'hFFFB);
      add(0,1,0,1, 35'd2, 0,35'd0, 2, 4'b1100, 3'd1, 16'hFFF9);
      add(0,1,0,1, 35'd2, 0,35'd0, 2, 4'b1001, 3'd7, 16'hFFF7);

      // reset state
      repeat (2) tick_edge();
      chk("reset_coils", 64'(coils_h), 64'h0);
      chk("reset_tick",  64'(tick_h),  64'h0);
      chk("reset_idx",   64'(idx_h),   64'h0);
      chk("reset_pos",   64'(pos_h),   64'h0);
      rst = 1'b1;
      tick_edge();
      chk("idle_hold_coils",   64'(coils_h), 64'b1000);
      chk("idle_nohold_coils", 64'(coils_n), 64'b0000);

      for (int k = 0; k < vecs.size(); k++) begin
         int cnt;
         if (vecs[k].rst_first) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
         end
         enable = vecs[k].en;
         dir = vecs[k].dr;
         step = vecs[k].stp;
         time_to_count = vecs[k].ttc;
         cnt = 0;
         do begin
            tick_edge();
            cnt++;
            if (vecs[k].mid != 0 && cnt == vecs[k].mid) time_to_count = vecs[k].ttc2;
         end while (!tick_h && cnt < 100);
         chk($sformatf("v%0d_interval", k), 64'(cnt), 64'(vecs[k].interval));
         chk($sformatf("v%0d_coils", k), 64'(coils_h), 64'(vecs[k].coils));
         chk($sformatf("v%0d_coils_nohold", k), 64'(coils_n), 64'(vecs[k].coils));
         chk($sformatf("v%0d_idx", k), 64'(idx_h), 64'(vecs[k].idx));
         chk($sformatf("v%0d_pos", k), 64'(pos_h), 64'(vecs[k].pos));
      end

      // enable drops exactly when cnt == period-1: no step may be taken
      tick_edge();
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick_edge();
         chk($sformatf("stop_no_tick_%0d", k), 64'(tick_h), 64'h0);
      end
      chk("stop_idx", 64'(idx_h), 64'd7);
      chk("stop_pos", 64'(pos_h), 64'hFFF7);
      chk("stop_hold_coils", 64'(coils_h), 64'b1001);
      chk("stop_nohold_coils", 64'(coils_n), 64'b0000);

      // asynchronous reset in the middle of RUN, checked before any clock edge
      enable = 1'b1;
      time_to_count = 35'd1;
      repeat (3) tick_edge();
      rst = 1'b0;
      #1;
      chk("async_rst_coils", 64'(coils_h), 64'h0);
      chk("async_rst_tick",  64'(tick_h),  64'h0);
      chk("async_rst_idx",   64'(idx_h),   64'h0);
      chk("async_rst_pos",   64'(pos_h),   64'h0);
      chk("async_rst_nohold_coils", 64'(coils_n), 64'h0);
      rst = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
